// File: rtl/double_cmp_arbiter.sv
// Round-robin arbiter in front of one pipelined IEEE-754 double comparator.
// Results come back in acceptance order, tagged with the requester index.
module double_cmp_arbiter #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_z,
    output logic                 busy
);

    logic [IDW-1:0] ptr_reg;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(ptr_reg) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(ptr_reg) + k) % NREQ);
            end
        end
        if (!rst_n) begin
            gnt_found = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = gnt_found && (gnt_idx == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= IDW'(NREQ - 1);
        end else if (gnt_found) begin
            ptr_reg <= gnt_idx;
        end
    end

    // Stage 1: operands of the granted requester. Data only loads on a grant
    // so that the final stage keeps showing the last result.
    logic           s1_valid_reg;
    logic [1:0]     s1_op_reg;
    logic [IDW-1:0] s1_id_reg;
    logic [63:0]    s1_a_reg;
    logic [63:0]    s1_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= 2'b01;  // NE on 0 vs 0 keeps rsp_z low when PIPE_DEPTH is 1
            s1_id_reg    <= '0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
        end else begin
            s1_valid_reg <= gnt_found;
            if (gnt_found) begin
                s1_op_reg <= req_op[2*int'(gnt_idx) +: 2];
                s1_id_reg <= gnt_idx;
                s1_a_reg  <= req_a[64*int'(gnt_idx) +: 64];
                s1_b_reg  <= req_b[64*int'(gnt_idx) +: 64];
            end
        end
    end

    logic a_nan, b_nan, both_zero, mag_a_lt, mag_b_lt, is_eq, is_lt, cmp_z;

    always_comb begin
        a_nan     = (&s1_a_reg[62:52]) && (|s1_a_reg[51:0]);
        b_nan     = (&s1_b_reg[62:52]) && (|s1_b_reg[51:0]);
        both_zero = (s1_a_reg[62:0] == 63'd0) && (s1_b_reg[62:0] == 63'd0);
        mag_a_lt  = s1_a_reg[62:0] < s1_b_reg[62:0];
        mag_b_lt  = s1_b_reg[62:0] < s1_a_reg[62:0];
        is_eq     = !(a_nan || b_nan) && ((s1_a_reg == s1_b_reg) || both_zero);
        is_lt     = 1'b0;
        if (!(a_nan || b_nan) && !both_zero) begin
            if (s1_a_reg[63] != s1_b_reg[63]) begin
                is_lt = s1_a_reg[63];
            end else begin
                // Sign-magnitude: negative values order in reverse of magnitude
                is_lt = s1_a_reg[63] ? mag_b_lt : mag_a_lt;
            end
        end
        case (s1_op_reg)
            2'b00:   cmp_z = is_eq;
            2'b01:   cmp_z = !is_eq;
            2'b10:   cmp_z = is_lt;
            default: cmp_z = is_lt || is_eq;
        endcase
    end

    logic [PIPE_DEPTH:1] v_line;
    logic [IDW-1:0]      id_line [PIPE_DEPTH:1];
    logic                z_line  [PIPE_DEPTH:1];

    assign v_line[1]  = s1_valid_reg;
    assign id_line[1] = s1_id_reg;
    assign z_line[1]  = cmp_z;

    generate
        for (genvar gi = 2; gi <= PIPE_DEPTH; gi++) begin : g_stage
            logic           v_reg;
            logic [IDW-1:0] id_reg;
            logic           z_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_reg  <= 1'b0;
                    id_reg <= '0;
                    z_reg  <= 1'b0;
                end else begin
                    v_reg <= v_line[gi-1];
                    if (v_line[gi-1]) begin
                        id_reg <= id_line[gi-1];
                        z_reg  <= z_line[gi-1];
                    end
                end
            end

            assign v_line[gi]  = v_reg;
            assign id_line[gi] = id_reg;
            assign z_line[gi]  = z_reg;
        end
    endgenerate

    assign rsp_valid = v_line[PIPE_DEPTH];
    assign rsp_id    = id_line[PIPE_DEPTH];
    assign rsp_z     = z_line[PIPE_DEPTH];
    assign busy      = |v_line;

endmodule

// File: tb/tb_double_cmp_arbiter.sv
// Scoreboard bench: a round-robin model predicts grants at each negedge and
// queues expected results, which are popped as the comparator answers.
module tb_double_cmp_arbiter;
    localparam int NREQ       = 4;
    localparam int IDW        = 2;
    localparam int PIPE_DEPTH = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [64*NREQ-1:0]   req_a;
    logic [64*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_z;
    logic                 busy;

    double_cmp_arbiter #(.NREQ(NREQ), .IDW(IDW), .PIPE_DEPTH(PIPE_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [IDW-1:0] id; logic z; } exp_t;
    typedef struct { logic [1:0] op; logic [63:0] a; logic [63:0] b; } vec_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mptr = NREQ - 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference compare using the simulator's own IEEE-754 arithmetic
    function automatic logic ref_cmp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        real ra, rb;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        case (op)
            2'b00:   return ra == rb;
            2'b01:   return !(ra == rb);
            2'b10:   return ra < rb;
            default: return ra <= rb;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        exp_t            e;
        exp_ready = '0;
        if (!rst_n) begin
            sb_q.delete();
            mptr = NREQ - 1;
            chk("ready_in_reset", req_ready, 0);
            chk("rsp_valid_in_reset", rsp_valid, 0);
            chk("busy_in_reset", busy, 0);
        end else begin
            chk("busy", busy, sb_q.size() != 0);
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    $display("rsp id=%0d z=%0d (exp id=%0d z=%0d)", rsp_id, rsp_z, e.id, e.z);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_z", rsp_z, e.z);
                end
            end
            for (int k = 1; k <= NREQ; k++) begin
                if (exp_ready == '0 && req_valid[(mptr + k) % NREQ]) begin
                    exp_ready[(mptr + k) % NREQ] = 1'b1;
                end
            end
            chk("req_ready", req_ready, exp_ready);
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ready[i]) begin
                    e.id = IDW'(i);
                    e.z  = ref_cmp(req_op[2*i +: 2], req_a[64*i +: 64], req_b[64*i +: 64]);
                    sb_q.push_back(e);
                    mptr = i;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        req_valid[i]      = 1'b1;
        req_op[2*i +: 2]  = op;
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        set_req(i, op, a, b);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                tick(1);
                clr_req(i);
                return;
            end
        end
        chk("grant_timeout", 0, 1);
        clr_req(i);
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && sb_q.size() != 0; n++) tick(1);
        tick(2);
        chk("drain", sb_q.size(), 0);
    endtask

    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;
    localparam logic [63:0] QNAN  = 64'h7FF8000000000000;
    localparam logic [63:0] NZERO = 64'h8000000000000000;

    vec_t vecs [0:15];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{2'b00, QNAN, ONE}, '{2'b01, QNAN, ONE}, '{2'b10, QNAN, ONE}, '{2'b11, QNAN, ONE},
            '{2'b00, NZERO, 64'd0}, '{2'b10, NZERO, 64'd0}, '{2'b11, NZERO, 64'd0},
            '{2'b10, 64'hC000000000000000, 64'hBFF0000000000000},
            '{2'b10, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000},
            '{2'b10, 64'h0000000000000001, 64'h0000000000000002},
            '{2'b00, 64'hFFF0000000000000, 64'hFFF0000000000000},
            '{2'b11, ONE, QNAN},
            '{2'b01, ONE, ONE},
            '{2'b10, ONE, 64'hBFF0000000000000},
            '{2'b11, 64'h8000000000000001, NZERO},
            '{2'b10, 64'hFFF0000000000000, 64'hFFEFFFFFFFFFFFFF}
        };
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Single request, then wait for idle
        send(0, 2'b00, ONE, ONE);
        drain();

        // All four requesters continuously valid
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b10, ONE, TWO);
        tick(12);
        for (int i = 0; i < NREQ; i++) clr_req(i);
        drain();

        // Compare corner cases across requesters
        for (int v = 0; v < 16; v++) send(v % NREQ, vecs[v].op, vecs[v].a, vecs[v].b);
        drain();

        // Fresh reset, then R0 and R2 together: R0 first, then R2
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
        set_req(0, 2'b11, TWO, ONE);
        set_req(2, 2'b11, ONE, TWO);
        #1 chk("r0_first", req_ready, 4'b0001);
        tick(1); clr_req(0);
        #1 chk("r2_second", req_ready, 4'b0100);
        tick(1); clr_req(2);
        drain();

        // R2 withdraws before it is granted
        set_req(1, 2'b00, ONE, ONE);
        set_req(2, 2'b00, TWO, TWO);
        tick(1);
        clr_req(1); clr_req(2);
        drain();

        // Reset with two operations in flight
        set_req(1, 2'b10, ONE, TWO);
        set_req(3, 2'b10, TWO, ONE);
        tick(2);
        clr_req(1); clr_req(3);
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_z", rsp_z, 0);
        set_req(3, 2'b00, ONE, ONE);
        #1 chk("rst_ready", req_ready, 0);
        tick(2);
        rst_n = 1'b1;
        set_req(0, 2'b00, ONE, ONE);
        #1 chk("first_after_rst", req_ready, 4'b0001);
        tick(1); clr_req(0);
        tick(1); clr_req(3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
